// File: rtl/btn_input.sv
// Push-button front end: per-channel sync + debounce with press/release pulses, driving an
// up/down/clear/hold value. Define AUTOREPEAT_EN to add press auto-repeat on channels 0 and 1.
// The release pulse output is named release_pulse because "release" is a reserved word.

module btn_input #(
   parameter int unsigned NBTN    = 4,
   parameter int unsigned BITS    = 4,
   parameter int unsigned DB_BITS = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NBTN-1:0] btn_n,
   output logic [NBTN-1:0] level,
   output logic [NBTN-1:0] press,
   output logic [NBTN-1:0] release_pulse,
   output logic [BITS-1:0] value,
   output logic            hold
);

   logic [NBTN-1:0]    sync1_q, sync2_q, s;
   logic [NBTN-1:0]    level_q, level_d;
   logic [NBTN-1:0]    press_q, press_d, deb_press;
   logic [NBTN-1:0]    rel_q, rel_d;
   logic [DB_BITS-1:0] cnt_q [NBTN];
   logic [DB_BITS-1:0] cnt_d [NBTN];
   logic [BITS-1:0]    value_q, value_d;
   logic               hold_q, hold_d;

   assign s = ~sync2_q;

   always_comb begin
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i]     = cnt_q[i];
         level_d[i]   = level_q[i];
         deb_press[i] = 1'b0;
         rel_d[i]     = 1'b0;
         if (s[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + DB_BITS'(1);
         end else begin
            // Level accepted: pulse is registered alongside the new level.
            level_d[i]   = s[i];
            cnt_d[i]     = '0;
            deb_press[i] = s[i];
            rel_d[i]     = ~s[i];
         end
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int unsigned RptW = DB_BITS + 4;
   localparam logic [RptW-1:0] RptFirst = '1;
   localparam logic [RptW-1:0] RptNext  = {2'b00, {(DB_BITS + 2){1'b1}}};

   logic [RptW-1:0] rpt_q [2];
   logic [RptW-1:0] rpt_d [2];
   logic [1:0]      rep_q, rep_d, rpt_fire;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rpt_d[i]    = rpt_q[i];
         rep_d[i]    = rep_q[i];
         rpt_fire[i] = 1'b0;
         // A repeat never coincides with the release edge of the same channel.
         if (!level_q[i] || rel_d[i]) begin
            rpt_d[i] = '0;
            rep_d[i] = 1'b0;
         end else if (rpt_q[i] == (rep_q[i] ? RptNext : RptFirst)) begin
            rpt_fire[i] = 1'b1;
            rpt_d[i]    = '0;
            rep_d[i]    = 1'b1;
         end else begin
            rpt_d[i] = rpt_q[i] + RptW'(1);
         end
      end
   end

   assign press_d = deb_press | {{(NBTN - 2){1'b0}}, rpt_fire};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
         for (int i = 0; i < 2; i++) rpt_q[i] <= '0;
      end else begin
         rep_q <= rep_d;
         for (int i = 0; i < 2; i++) rpt_q[i] <= rpt_d[i];
      end
   end
`else
   assign press_d = deb_press;
`endif

   // Acts on the registered pulses; hold toggles but the other action sees the old hold.
   always_comb begin
      value_d = value_q;
      hold_d  = hold_q ^ press_q[3];
      if (press_q[2]) begin
         value_d = '0;
      end else if (hold_q) begin
         value_d = value_q;
      end else if (press_q[0] && press_q[1]) begin
         value_d = value_q;
      end else if (press_q[0]) begin
         value_d = value_q + BITS'(1);
      end else if (press_q[1]) begin
         value_d = value_q - BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         value_q <= '0;
         hold_q  <= 1'b0;
         for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         value_q <= value_d;
         hold_q  <= hold_d;
         for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = rel_q;
   assign value         = value_q;
   assign hold          = hold_q;

endmodule

// File: tb/tb_btn_input.sv
// Bench for btn_input (DB_BITS = 3): directed table, hand-written corner sequences, and a
// random run checked every cycle against a window-based reference model.

module tb_btn_input;

   localparam int NBTN    = 4;
   localparam int BITS    = 4;
   localparam int DB_BITS = 3;
   localparam int WIN     = 1 << DB_BITS;
   localparam int RPT1    = 1 << (DB_BITS + 4);
   localparam int RPTN    = 1 << (DB_BITS + 2);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NBTN-1:0] btn_n = '1;
   logic [NBTN-1:0] level, press, rel;
   logic [BITS-1:0] value;
   logic            hold;

   btn_input #(.NBTN(NBTN), .BITS(BITS), .DB_BITS(DB_BITS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_n        (btn_n),
      .level        (level),
      .press        (press),
      .release_pulse(rel),
      .value        (value),
      .hold         (hold)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [NBTN-1:0] padh[$];
   logic [NBTN-1:0] m_level, m_press, m_rel;
   logic [BITS-1:0] m_value;
   logic            m_hold;
   int              ecnt;
   int              rise[2];

   // Observation counters
   int pcnt[NBTN];
   int rcnt[NBTN];
   int ccnt;
   int p0_at[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      padh.delete();
      repeat (WIN + 2) padh.push_back('1);
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_value = '0;
      m_hold  = 1'b0;
      ecnt    = 0;
      rise[0] = 0;
      rise[1] = 0;
   endtask

   // A channel's level flips once its sampled value (pad delayed two edges, inverted) has
   // differed from the stable level on the last WIN consecutive edges.
   task automatic model_edge(input logic [NBTN-1:0] pad);
      logic [NBTN-1:0] old_press, newl;
      logic            sb;
      bit              alld;
      int              age;
      old_press = m_press;
      for (int i = 0; i < NBTN; i++) begin
         alld = 1'b1;
         for (int j = 0; j < WIN; j++) begin
            sb = ~padh[1 + j][i];
            if (sb == m_level[i]) alld = 1'b0;
         end
         newl[i]    = alld ? ~m_level[i] : m_level[i];
         m_press[i] = alld & ~m_level[i];
         m_rel[i]   = alld & m_level[i];
      end
`ifdef AUTOREPEAT_EN
      for (int i = 0; i < 2; i++) begin
         if (m_press[i]) begin
            rise[i] = ecnt;
         end else if (m_level[i] && newl[i]) begin
            age = ecnt - rise[i];
            if (age == RPT1 || (age > RPT1 && (age - RPT1) % RPTN == 0)) m_press[i] = 1'b1;
         end
      end
`endif
      m_level = newl;
      if (old_press[2])                     m_value = '0;
      else if (m_hold)                      m_value = m_value;
      else if (old_press[0] && old_press[1]) m_value = m_value;
      else if (old_press[0])                m_value = m_value + 4'd1;
      else if (old_press[1])                m_value = m_value - 4'd1;
      if (old_press[3]) m_hold = ~m_hold;
      padh.push_front(pad);
      void'(padh.pop_back());
      ecnt++;
   endtask

   task automatic clr_obs();
      for (int i = 0; i < NBTN; i++) begin
         pcnt[i] = 0;
         rcnt[i] = 0;
      end
      ccnt = 0;
      p0_at.delete();
   endtask

   task automatic cycle(input logic [NBTN-1:0] pad);
      btn_n = pad;
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge(pad);
      #1;
      ccnt++;
      for (int i = 0; i < NBTN; i++) begin
         if (press[i]) pcnt[i]++;
         if (rel[i])   rcnt[i]++;
      end
      if (press[0]) p0_at.push_back(ccnt);
      chk("model{level,press,release,value,hold}", int'({level, press, rel, value, hold}),
          int'({m_level, m_press, m_rel, m_value, m_hold}));
   endtask

   task automatic push(input logic [NBTN-1:0] mask, input int len);
      repeat (len) cycle(~mask);
      repeat (len) cycle('1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) cycle('1);
      rst_n = 1'b1;
      clr_obs();
   endtask

   typedef struct {
      logic [NBTN-1:0] mask;
      logic [BITS-1:0] val;
      logic            hld;
   } vec_t;

   vec_t tbl[15];
   int   first;
   int   run_left[NBTN];
   logic [NBTN-1:0] rpad;

   initial begin
      tbl[0]  = '{4'b0001, 4'd1,  1'b0};
      tbl[1]  = '{4'b0001, 4'd2,  1'b0};
      tbl[2]  = '{4'b0010, 4'd1,  1'b0};
      tbl[3]  = '{4'b0010, 4'd0,  1'b0};
      tbl[4]  = '{4'b0010, 4'd15, 1'b0};
      tbl[5]  = '{4'b1000, 4'd15, 1'b1};
      tbl[6]  = '{4'b0001, 4'd15, 1'b1};
      tbl[7]  = '{4'b0010, 4'd15, 1'b1};
      tbl[8]  = '{4'b0100, 4'd0,  1'b1};
      tbl[9]  = '{4'b1000, 4'd0,  1'b0};
      tbl[10] = '{4'b0011, 4'd0,  1'b0};
      tbl[11] = '{4'b0001, 4'd1,  1'b0};
      tbl[12] = '{4'b1100, 4'd0,  1'b1};
      tbl[13] = '{4'b1001, 4'd0,  1'b0};
      tbl[14] = '{4'b0001, 4'd1,  1'b0};

      model_reset();
      clr_obs();
      #1;
      do_reset();

      // Idle after reset
      repeat (50) cycle('1);
      chk("idle_level", int'(level), 0);
      chk("idle_value", int'(value), 0);
      chk("idle_hold", int'(hold), 0);
      chk("idle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + rcnt[0] + rcnt[1] + rcnt[2]
          + rcnt[3], 0);

      // Press latency: pulse on the 10th edge after the pad edge
      clr_obs();
      repeat (20) cycle(4'b1110);
      chk("latency_press_cycle", (p0_at.size() > 0) ? p0_at[0] : -1, 10);
      chk("latency_press_count", pcnt[0], 1);
      chk("latency_value", int'(value), 1);
      clr_obs();
      repeat (20) cycle('1);
      chk("release_count", rcnt[0], 1);
      chk("release_value", int'(value), 1);

      // Bounce: 5 low / 2 high, then steady low
      clr_obs();
      repeat (4) begin
         repeat (5) cycle(4'b1110);
         repeat (2) cycle(4'b1111);
      end
      chk("bounce_no_press", pcnt[0], 0);
      first = ccnt;
      repeat (20) cycle(4'b1110);
      chk("bounce_press_cycle", (p0_at.size() > 0) ? p0_at[0] - first : -1, 10);
      chk("bounce_press_count", pcnt[0], 1);
      repeat (20) cycle('1);
      chk("bounce_value", int'(value), 2);

      // Wrap-around
      do_reset();
      push(4'b0010, 12);
      chk("wrap_down", int'(value), 15);
      repeat (16) push(4'b0001, 12);
      chk("wrap_16_up", int'(value), 15);
      chk("wrap_press_count", pcnt[0], 16);

      // Table of single button actions
      do_reset();
      for (int k = 0; k < 15; k++) begin
         repeat (14) cycle(~tbl[k].mask);
         chk($sformatf("tbl%0d_level", k), int'(level), int'(tbl[k].mask));
         repeat (14) cycle('1);
         chk($sformatf("tbl%0d_value", k), int'(value), int'(tbl[k].val));
         chk($sformatf("tbl%0d_hold", k), int'(hold), int'(tbl[k].hld));
      end

      // Reset mid-debounce with buttons still held afterwards
      do_reset();
      push(4'b0001, 12);
      push(4'b1000, 12);
      repeat (15) cycle(4'b1101);
      repeat (5) cycle(4'b1100);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_outputs", int'({level, press, rel, value, hold}), 0);
      repeat (3) cycle(4'b1100);
      rst_n = 1'b1;
      clr_obs();
      repeat (9) cycle(4'b1100);
      chk("post_rst_no_stale", pcnt[0] + pcnt[1] + rcnt[0] + rcnt[1], 0);
      cycle(4'b1100);
      chk("post_rst_press", int'(press), 4'b0011);
      repeat (10) cycle(4'b1100);
      repeat (20) cycle('1);
      chk("post_rst_both_value", int'(value), 0);
      chk("post_rst_press_count", pcnt[0] + pcnt[1], 2);

      // Long hold of button 0
      do_reset();
      repeat (400) cycle(4'b1110);
      repeat (20) cycle('1);
`ifdef AUTOREPEAT_EN
      chk("ar_count", pcnt[0], 10);
      chk("ar_first_gap", (p0_at.size() > 1) ? p0_at[1] - p0_at[0] : -1, RPT1);
      chk("ar_next_gap", (p0_at.size() > 2) ? p0_at[2] - p0_at[1] : -1, RPTN);
      chk("ar_value", int'(value), 10);
`else
      chk("hold_single_press", pcnt[0], 1);
      chk("hold_value", int'(value), 1);
`endif

      // Random pads against the model
      do_reset();
      rpad = '1;
      for (int i = 0; i < NBTN; i++) run_left[i] = $urandom_range(1, 20);
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NBTN; i++) begin
            if (run_left[i] == 0) begin
               rpad[i]     = ~rpad[i];
               run_left[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9)
                                                          : $urandom_range(10, 250);
            end
            run_left[i]--;
         end
         cycle(rpad);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btn_input.md
Name: btn_input

Overview:
- Input-side companion to the LED counter display: reads the four board push-buttons instead of driving the four LEDs.
- Each raw button pad is synchronised and debounced, and a clean level plus one-cycle press/release pulses are produced per button.
- A BITS-wide user value is maintained from button events (up/down/clear/hold), to be driven onto the LD1..LD4 display path.
- Sits directly behind the button pads, in the single board clock domain.

Parameters:
- NBTN, 4: number of button channels; channels 0..3 have fixed functions, any extras give level/pulse outputs only.
- BITS, 4: width of value output.
- DB_BITS, 16: debounce counter width; a new level must persist 2^DB_BITS consecutive cycles to be accepted.

Ports:
- clk  in  1  board clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_n  in  NBTN  raw button pads, active-low (0 = pressed), asynchronous to clk.
- level  out  NBTN  debounced state, 1 = pressed.
- press  out  NBTN  one-cycle pulse on accepted press.
- release  out  NBTN  one-cycle pulse on accepted release.
- value  out  BITS  user value.
- hold  out  1  1 = value frozen.

Behaviour:
- Reset (rst_n low, takes effect immediately, async): synchroniser flops = 1 (released), debounce counters = 0, level = 0, press = 0, release = 0, value = 0, hold = 0.
- Synchroniser: 2 flops per channel, then inverted to get sampled level s (1 = pressed).
- Debounce, per channel:
  - Stable state L is exported as level; counter C is DB_BITS wide.
  - If s == L: C <= 0.
  - If s != L and C != all-ones: C <= C+1.
  - If s != L and C == all-ones: L <= s, C <= 0, and the matching pulse fires (press if new L = 1, else release) in the same cycle L changes.
- Timing: a clean input change appears on level 2 + 2^DB_BITS cycles after the pad edge (±1 for async sampling).
- Any glitch shorter than 2^DB_BITS cycles resets C and never reaches level.
- press and release are registered, high exactly one cycle, and never both high on one channel.
- value update, evaluated each cycle from that cycle's press pulses, in priority order:
  - press[2]: value <= 0. Clears even when hold = 1.
  - Else if hold = 1: no change.
  - Else press[0] and press[1] together: no change.
  - Else press[0]: value+1. Else press[1]: value-1.
- value arithmetic is modulo 2^BITS: all-ones+1 -> 0, 0-1 -> all-ones.
- press[3] toggles hold. The toggle and any other action in the same cycle both apply; the other action sees the old hold.
- Reset asserted mid-debounce discards partial counts. After release of rst_n, a button already held is accepted as a press after the full debounce time.

Optional Feature:
- Macro AUTOREPEAT_EN.
- When defined, channels 0 and 1 auto-repeat:
  - While level stays 1, the channel's press pulse fires again after 2^(DB_BITS+4) cycles of continuous hold.
  - It then repeats every 2^(DB_BITS+2) cycles until release.
  - Repeat pulses are indistinguishable from initial press pulses and drive value identically.
  - The repeat timer resets on release and on reset; one repeat timer per channel.
- When undefined: no repeat logic is present, and a held button yields exactly one press pulse.

Test Plan (DB_BITS = 3 for simulation):
- Reset, pads all 1, 50 cycles -> level = 0, no pulses, value = 0, hold = 0.
- btn_n[0] held low 20 cycles -> single press[0] pulse about 10 cycles after the edge, value = 1. Pad released -> single release[0] pulse, value stays 1.
- btn_n[0] bouncing low 5 cycles / high 2 cycles repeatedly, then steady low -> press only after 8 consecutive steady low cycles, exactly one pulse, value = 1.
- From value = 0, one press of button 1 -> value = 15. 16 presses of button 0 -> value returns to the start value.
- Press button 3 -> hold = 1; press button 0 -> value unchanged; press button 2 -> value = 0; press button 3 -> hold = 0.
- Buttons 0 and 1 pressed in the same cycle -> value unchanged. rst_n pulsed low mid-debounce -> all outputs 0 immediately, no stale pulse afterwards.
- With AUTOREPEAT_EN: button 0 held 400 cycles -> first repeat at 128 cycles after the initial press, then every 32 cycles; value = 1 + 9 = 10 (mod 16).
